// File: rtl/exc_ctrl.sv
// Exception and pipeline-control sequencer for the five-stage MIPS core.
// Picks the top-priority MEM-stage event, pulses the CP0 port, flushes, arbitrates stalls.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   stallreq_id/ex           stall requests from ID and EX
//   mem_*                    MEM-stage valid, exception flags, PC, delay-slot flag
//   cp0_status/cause/epc     live CP0 registers
//   wb_cp0_we/waddr/wdata    WB-stage CP0 write, forwarded ahead of the CP0 values
//   excepttype_o             exception code to CP0 (single-cycle pulse)
//   current_inst_addr_o      faulting PC to CP0 (single-cycle pulse)
//   is_in_delayslot_o        delay-slot flag to CP0 (single-cycle pulse)
//   flush_o, new_pc_o        pipeline flush and redirect PC
//   stall_o                  stall vector {wb,mem,ex,id,if,pc}
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        mem_valid,
    input  logic        mem_syscall,
    input  logic        mem_inst_invalid,
    input  logic        mem_trap,
    input  logic        mem_ovf,
    input  logic        mem_eret,
    input  logic [31:0] mem_pc,
    input  logic        mem_in_delayslot,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    input  logic        wb_cp0_we,
    input  logic [4:0]  wb_cp0_waddr,
    input  logic [31:0] wb_cp0_wdata,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [5:0]  stall_o
);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

    state_t      state;
    logic [1:0]  cnt;

    logic [31:0] status_f;
    logic [31:0] cause_f;
    logic [31:0] epc_f;
    logic        int_pend;
    logic [31:0] code;
    logic [31:0] target;
    logic        unused_bits;

    // WB writes land in CP0 next cycle, so bypass them here.
    always_comb begin
        status_f = cp0_status;
        cause_f  = cp0_cause;
        epc_f    = cp0_epc;
        if (wb_cp0_we) begin
            if (wb_cp0_waddr == 5'd12) status_f = wb_cp0_wdata;
            if (wb_cp0_waddr == 5'd13) cause_f[9:8] = wb_cp0_wdata[9:8];
            if (wb_cp0_waddr == 5'd14) epc_f = wb_cp0_wdata;
        end
    end

    assign unused_bits = ^{status_f[31:16], status_f[7:2],
                           cause_f[31:16], cause_f[7:0]};

    // IE=1, EXL=0 and some unmasked pending line.
    assign int_pend = status_f[0] & ~status_f[1]
                    & (|(cause_f[15:8] & status_f[15:8]));

    always_comb begin
        code = 32'h0;
        if (state == IDLE && mem_valid) begin
            if (int_pend)              code = 32'h1;
            else if (mem_syscall)      code = 32'h8;
            else if (mem_inst_invalid) code = 32'ha;
            else if (mem_trap)         code = 32'hd;
            else if (mem_ovf)          code = 32'hc;
            else if (mem_eret)         code = 32'he;
        end
    end

    assign target = (code == 32'he) ? epc_f : EXC_VECTOR;

    // An exception being taken or flushed overrides any stall.
    always_comb begin
        stall_o = 6'b000000;
        if (state == IDLE && code == 32'h0) begin
            if (stallreq_ex)      stall_o = 6'b001111;
            else if (stallreq_id) stall_o = 6'b000111;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state               <= IDLE;
            cnt                 <= 2'd0;
            excepttype_o        <= 32'h0;
            current_inst_addr_o <= 32'h0;
            is_in_delayslot_o   <= 1'b0;
            flush_o             <= 1'b0;
            new_pc_o            <= 32'h0;
        end else begin
            // CP0 port is a one-cycle pulse.
            excepttype_o        <= 32'h0;
            current_inst_addr_o <= 32'h0;
            is_in_delayslot_o   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (code != 32'h0) begin
                        excepttype_o        <= code;
                        current_inst_addr_o <= mem_pc;
                        is_in_delayslot_o   <= mem_in_delayslot;
                        flush_o             <= 1'b1;
                        new_pc_o            <= target;
                        cnt                 <= CNT_INIT;
                        state               <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (cnt == 2'd0) begin
                        flush_o  <= 1'b0;
                        new_pc_o <= 32'h0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
